// File: rtl/sha256_ex_unit.sv
// Execute-stage SHA-256 compression engine: one round per ROUND command, an
// 8-cycle stalling FINAL that folds a..h into H0..H7, and READ of hash words.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | accepting INIT / ROUND / FINAL / READ commands
// FINAL   | folding var[idx] into H[idx], idx 0..7; pipeline stalled

module sha256_ex_unit #(
    parameter int ROUNDS = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_sha_in,
    input  logic [1:0]  sel_mux_res_sha_in,
    input  logic [31:0] re_adder_32_in,
    input  logic [31:0] w2_in,
    output logic        stall_out,
    output logic [31:0] result_out,
    output logic        result_valid_out,
    output logic [5:0]  round_cnt_out,
    output logic        done_out,
    output logic        error_out
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FINAL = 1'b1
    } state_t;

    localparam logic [1:0] CMD_INIT  = 2'b00;
    localparam logic [1:0] CMD_ROUND = 2'b01;
    localparam logic [1:0] CMD_FINAL = 2'b10;
    localparam logic [1:0] CMD_READ  = 2'b11;
    localparam logic [5:0] LAST_RND  = 6'(ROUNDS - 1);

    state_t      state_q, state_d;
    logic [31:0] var_q  [8];
    logic [31:0] var_d  [8];
    logic [31:0] hash_q [8];
    logic [31:0] hash_d [8];
    logic [5:0]  round_cnt_q, round_cnt_d;
    logic        done_q, done_d;
    logic [2:0]  idx_q, idx_d;
    logic [31:0] result_q, result_d;
    logic        valid_q, valid_d;
    logic        error_q, error_d;

    logic [31:0] big_sig0, big_sig1, ch, maj, t1, t2;
    logic [31:0] fin_sum;
    logic        unused_w2_hi;

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] iv(input int i);
        case (i)
            0:       return 32'h6a09e667;
            1:       return 32'hbb67ae85;
            2:       return 32'h3c6ef372;
            3:       return 32'ha54ff53a;
            4:       return 32'h510e527f;
            5:       return 32'h9b05688c;
            6:       return 32'h1f83d9ab;
            default: return 32'h5be0cd19;
        endcase
    endfunction

    // Round datapath: var[0..7] = a..h
    assign big_sig1 = ror(var_q[4], 6) ^ ror(var_q[4], 11) ^ ror(var_q[4], 25);
    assign big_sig0 = ror(var_q[0], 2) ^ ror(var_q[0], 13) ^ ror(var_q[0], 22);
    assign ch       = (var_q[4] & var_q[5]) ^ (~var_q[4] & var_q[6]);
    assign maj      = (var_q[0] & var_q[1]) ^ (var_q[0] & var_q[2]) ^ (var_q[1] & var_q[2]);
    assign t1       = var_q[7] + big_sig1 + ch + re_adder_32_in;
    assign t2       = big_sig0 + maj;

    // The single adder shared by all eight finalize steps
    assign fin_sum  = hash_q[idx_q] + var_q[idx_q];

    assign unused_w2_hi = ^w2_in[31:3];

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            for (int i = 0; i < 8; i++) begin
                var_q[i]  <= '0;
                hash_q[i] <= '0;
            end
            round_cnt_q <= '0;
            done_q      <= 1'b0;
            idx_q       <= '0;
            result_q    <= '0;
            valid_q     <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            for (int i = 0; i < 8; i++) begin
                var_q[i]  <= var_d[i];
                hash_q[i] <= hash_d[i];
            end
            round_cnt_q <= round_cnt_d;
            done_q      <= done_d;
            idx_q       <= idx_d;
            result_q    <= result_d;
            valid_q     <= valid_d;
            error_q     <= error_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        var_d       = var_q;
        hash_d      = hash_q;
        round_cnt_d = round_cnt_q;
        done_d      = done_q;
        idx_d       = idx_q;
        result_d    = result_q;
        valid_d     = 1'b0;
        error_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_sha_in) begin
                    case (sel_mux_res_sha_in)
                        CMD_INIT: begin
                            for (int i = 0; i < 8; i++) begin
                                hash_d[i] = iv(i);
                                var_d[i]  = iv(i);
                            end
                            round_cnt_d = '0;
                            done_d      = 1'b0;
                        end
                        CMD_ROUND: begin
                            if (done_q) begin
                                error_d = 1'b1;
                            end else begin
                                var_d[7] = var_q[6];
                                var_d[6] = var_q[5];
                                var_d[5] = var_q[4];
                                var_d[4] = var_q[3] + t1;
                                var_d[3] = var_q[2];
                                var_d[2] = var_q[1];
                                var_d[1] = var_q[0];
                                var_d[0] = t1 + t2;
                                if (round_cnt_q == LAST_RND) begin
                                    round_cnt_d = '0;
                                    done_d      = 1'b1;
                                end else begin
                                    round_cnt_d = round_cnt_q + 6'd1;
                                end
                            end
                        end
                        CMD_FINAL: begin
                            if (done_q) begin
                                state_d = ST_FINAL;
                                idx_d   = '0;
                            end else begin
                                error_d = 1'b1;
                            end
                        end
                        CMD_READ: begin
                            result_d = hash_q[w2_in[2:0]];
                            valid_d  = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
            ST_FINAL: begin
                // Sum lands in both H and var so a..h start the next block
                hash_d[idx_q] = fin_sum;
                var_d[idx_q]  = fin_sum;
                if (idx_q == 3'd7) begin
                    state_d     = ST_IDLE;
                    done_d      = 1'b0;
                    round_cnt_d = '0;
                    idx_d       = '0;
                end else begin
                    idx_d = idx_q + 3'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        stall_out = (state_q == ST_FINAL);
    end

    assign result_out       = result_q;
    assign result_valid_out = valid_q;
    assign round_cnt_out    = round_cnt_q;
    assign done_out         = done_q;
    assign error_out        = error_q;

endmodule

// File: tb/tb_sha256_ex_unit.sv
// Directed bench for sha256_ex_unit: IV reads, the "abc" digest, FINAL stall
// timing, illegal-command pulses and reset during finalize.

module tb_sha256_ex_unit;

    logic        clk;
    logic        reset;
    logic        start_sha_in;
    logic [1:0]  sel_mux_res_sha_in;
    logic [31:0] re_adder_32_in;
    logic [31:0] w2_in;
    logic        stall_out;
    logic [31:0] result_out;
    logic        result_valid_out;
    logic [5:0]  round_cnt_out;
    logic        done_out;
    logic        error_out;

    int n_chk = 0;
    int n_err = 0;

    logic [31:0] k_tab [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    logic [31:0] iv_tab [8] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    logic [31:0] abc_digest [8] = '{
        32'hba7816bf, 32'h8f01cfea, 32'h414140de, 32'h5dae2223,
        32'hb00361a3, 32'h96177a9c, 32'hb410ff61, 32'hf20015ad
    };

    logic [31:0] w_sch [64];
    logic [31:0] wk    [64];

    sha256_ex_unit #(.ROUNDS(64)) dut (
        .clk                (clk),
        .reset              (reset),
        .start_sha_in       (start_sha_in),
        .sel_mux_res_sha_in (sel_mux_res_sha_in),
        .re_adder_32_in     (re_adder_32_in),
        .w2_in              (w2_in),
        .stall_out          (stall_out),
        .result_out         (result_out),
        .result_valid_out   (result_valid_out),
        .round_cnt_out      (round_cnt_out),
        .done_out           (done_out),
        .error_out          (error_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Called at a negedge; command is taken at the next posedge and the
    // task returns at the following negedge with outputs settled.
    task automatic issue(input logic [1:0] sel, input logic [31:0] wkv, input logic [31:0] w2v);
        start_sha_in       = 1'b1;
        sel_mux_res_sha_in = sel;
        re_adder_32_in     = wkv;
        w2_in              = w2v;
        @(negedge clk);
        start_sha_in       = 1'b0;
    endtask

    task automatic run_rounds(input int first, input int n);
        for (int i = first; i < first + n; i++) issue(2'b01, wk[i], 32'h0);
    endtask

    task automatic read_all(input string tag, input logic [31:0] exp [8]);
        for (int i = 0; i < 8; i++) begin
            issue(2'b11, 32'h0, 32'(i) | 32'hfffffff8);
            chk($sformatf("%s_v%0d", tag, i), {31'h0, result_valid_out}, 32'h1);
            chk($sformatf("%s_h%0d", tag, i), result_out, exp[i]);
        end
    endtask

    initial begin
        int stall_cnt;
        int guard;
        logic saw_valid;

        for (int t = 0; t < 64; t++) begin
            if (t < 16) begin
                w_sch[t] = (t == 0) ? 32'h61626380 : ((t == 15) ? 32'h00000018 : 32'h0);
            end else begin
                w_sch[t] = (ror(w_sch[t-2], 17) ^ ror(w_sch[t-2], 19) ^ (w_sch[t-2] >> 10))
                         + w_sch[t-7]
                         + (ror(w_sch[t-15], 7) ^ ror(w_sch[t-15], 18) ^ (w_sch[t-15] >> 3))
                         + w_sch[t-16];
            end
            wk[t] = w_sch[t] + k_tab[t];
        end

        reset = 1'b0;
        start_sha_in = 1'b0;
        sel_mux_res_sha_in = 2'b00;
        re_adder_32_in = '0;
        w2_in = '0;
        repeat (3) @(negedge clk);
        chk("rst_result", result_out, 32'h0);
        chk("rst_valid", {31'h0, result_valid_out}, 32'h0);
        chk("rst_stall", {31'h0, stall_out}, 32'h0);
        chk("rst_done", {31'h0, done_out}, 32'h0);
        chk("rst_cnt", {26'h0, round_cnt_out}, 32'h0);
        chk("rst_err", {31'h0, error_out}, 32'h0);
        reset = 1'b1;
        @(negedge clk);

        // IV reads with one-cycle valid pulse
        issue(2'b00, 32'h0, 32'h0);
        issue(2'b11, 32'h0, 32'h0);
        chk("iv_rd0_valid", {31'h0, result_valid_out}, 32'h1);
        chk("iv_rd0", result_out, 32'h6a09e667);
        @(negedge clk);
        chk("iv_valid_drop", {31'h0, result_valid_out}, 32'h0);
        chk("iv_result_hold", result_out, 32'h6a09e667);
        issue(2'b11, 32'h0, 32'h7);
        chk("iv_rd7", result_out, 32'h5be0cd19);

        // "abc" block
        issue(2'b00, 32'h0, 32'h0);
        run_rounds(0, 1);
        chk("cnt_after_1", {26'h0, round_cnt_out}, 32'd1);
        run_rounds(1, 62);
        chk("cnt_after_63", {26'h0, round_cnt_out}, 32'd63);
        chk("done_after_63", {31'h0, done_out}, 32'h0);
        run_rounds(63, 1);
        chk("cnt_wrap", {26'h0, round_cnt_out}, 32'd0);
        chk("done_after_64", {31'h0, done_out}, 32'h1);

        issue(2'b01, 32'hdeadbeef, 32'h0);
        chk("round65_err", {31'h0, error_out}, 32'h1);
        chk("round65_done", {31'h0, done_out}, 32'h1);
        @(negedge clk);
        chk("round65_err_drop", {31'h0, error_out}, 32'h0);

        // FINAL with READ held through the stall
        start_sha_in = 1'b1;
        sel_mux_res_sha_in = 2'b10;
        @(negedge clk);
        sel_mux_res_sha_in = 2'b11;
        w2_in = 32'h0;
        chk("stall_start", {31'h0, stall_out}, 32'h1);
        stall_cnt = 0;
        guard = 0;
        saw_valid = 1'b0;
        while (stall_out && guard < 20) begin
            if (result_valid_out) saw_valid = 1'b1;
            stall_cnt++;
            guard++;
            @(negedge clk);
        end
        if (result_valid_out) saw_valid = 1'b1;
        chk("stall_len", 32'(stall_cnt), 32'd8);
        chk("no_valid_in_stall", {31'h0, saw_valid}, 32'h0);
        @(negedge clk);
        start_sha_in = 1'b0;
        chk("read_after_stall_v", {31'h0, result_valid_out}, 32'h1);
        chk("read_after_stall", result_out, 32'hba7816bf);
        chk("fin_done", {31'h0, done_out}, 32'h0);
        chk("fin_cnt", {26'h0, round_cnt_out}, 32'h0);
        read_all("abc", abc_digest);

        // FINAL too early
        issue(2'b00, 32'h0, 32'h0);
        run_rounds(0, 10);
        issue(2'b10, 32'h0, 32'h0);
        chk("early_fin_err", {31'h0, error_out}, 32'h1);
        chk("early_fin_stall", {31'h0, stall_out}, 32'h0);
        chk("early_fin_cnt", {26'h0, round_cnt_out}, 32'd10);
        @(negedge clk);
        chk("early_fin_err_drop", {31'h0, error_out}, 32'h0);
        read_all("early", iv_tab);

        // Reset while finalize is at idx 4
        issue(2'b00, 32'h0, 32'h0);
        run_rounds(0, 64);
        issue(2'b10, 32'h0, 32'h0);
        repeat (4) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_fin_stall", {31'h0, stall_out}, 32'h0);
        chk("rst_fin_done", {31'h0, done_out}, 32'h0);
        reset = 1'b1;
        issue(2'b11, 32'h0, 32'h0);
        chk("rst_fin_rd_v", {31'h0, result_valid_out}, 32'h1);
        chk("rst_fin_rd0", result_out, 32'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
